// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the encryption datapath.
// Contents: round count, word/block typedefs, key-schedule FSM state type,
// round constant table and a lookup helper for it.
package aes_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StDone   = 2'd2
  } aes_ks_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for round 1..10; any other index yields 0.
  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (round == 4'(i)) r = RCON[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
// Ports: data_i - input byte, data_o - substituted byte.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule. Accepts a cipher key on a valid/ready
// handshake, derives round keys 1..10 one per clock and keeps all 11 keys.
// Ports:
//   Clock, ResetN                 - clock, asynchronous active-low reset
//   CipherKey, KeyValid, KeyReady - key input handshake (w0 = CipherKey[127:96])
//   RoundIdx, RoundKey            - combinational read of a stored key (0 if idx > 10)
//   KeyStrobe, KeyStrobeIdx/Data  - registered one-cycle notice of each key written
//   KeysValid                     - all keys of the current expansion are stored
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic [127:0] CipherKey,
  input  logic         KeyValid,
  output logic         KeyReady,
  input  logic [3:0]   RoundIdx,
  output logic [127:0] RoundKey,
  output logic         KeyStrobe,
  output logic [3:0]   KeyStrobeIdx,
  output logic [127:0] KeyStrobeData,
  output logic         KeysValid
);

  localparam int NumKeys = int'(NUM_ROUNDS) + 1;

  aes_ks_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  aes_block_t    keys_q [NumKeys];
  aes_block_t    keys_d [NumKeys];
  logic          keys_valid_q, keys_valid_d;
  logic          strobe_q, strobe_d;
  logic [3:0]    strobe_idx_q, strobe_idx_d;
  aes_block_t    strobe_data_q, strobe_data_d;

  logic          accept;
  logic [3:0]    prev_idx;
  aes_block_t    prev_key;
  aes_block_t    next_key;
  aes_word_t     rot_word;
  aes_word_t     sub_word;
  aes_word_t     t_word;
  aes_word_t     n0, n1, n2, n3;

  assign KeyReady = (state_q != StExpand);
  assign accept   = KeyValid && KeyReady;

  // Previous slot feeds the single shared expansion step; cnt_q = 0 selects nothing.
  assign prev_idx = cnt_q - 4'd1;

  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NumKeys; i++) begin
      if (prev_idx == 4'(i)) prev_key = keys_q[i];
    end
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot_word[8*b +: 8]),
      .data_o (sub_word[8*b +: 8])
    );
  end

  assign t_word   = sub_word ^ {aes_rcon(cnt_q), 24'h0};
  assign n0       = prev_key[127:96] ^ t_word;
  assign n1       = prev_key[95:64]  ^ n0;
  assign n2       = prev_key[63:32]  ^ n1;
  assign n3       = prev_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    keys_d        = keys_q;
    keys_valid_d  = keys_valid_q;
    strobe_d      = 1'b0;
    strobe_idx_d  = strobe_idx_q;
    strobe_data_d = strobe_data_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          keys_d[0]     = CipherKey;
          strobe_d      = 1'b1;
          strobe_idx_d  = 4'd0;
          strobe_data_d = CipherKey;
          cnt_d         = 4'd1;
          keys_valid_d  = 1'b0;
          state_d       = StExpand;
        end
      end
      StExpand: begin
        for (int i = 1; i < NumKeys; i++) begin
          if (cnt_q == 4'(i)) keys_d[i] = next_key;
        end
        strobe_d      = 1'b1;
        strobe_idx_d  = cnt_q;
        strobe_data_d = next_key;
        cnt_d         = cnt_q + 4'd1;
        if (cnt_q == 4'(NUM_ROUNDS)) begin
          state_d      = StDone;
          keys_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      keys_valid_q  <= 1'b0;
      strobe_q      <= 1'b0;
      strobe_idx_q  <= 4'd0;
      strobe_data_q <= '0;
      for (int i = 0; i < NumKeys; i++) keys_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      keys_valid_q  <= keys_valid_d;
      strobe_q      <= strobe_d;
      strobe_idx_q  <= strobe_idx_d;
      strobe_data_q <= strobe_data_d;
      for (int i = 0; i < NumKeys; i++) keys_q[i] <= keys_d[i];
    end
  end

  always_comb begin
    RoundKey = '0;
    for (int i = 0; i < NumKeys; i++) begin
      if (RoundIdx == 4'(i)) RoundKey = keys_q[i];
    end
  end

  assign KeyStrobe     = strobe_q;
  assign KeyStrobeIdx  = strobe_idx_q;
  assign KeyStrobeData = strobe_data_q;
  assign KeysValid     = keys_valid_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: directed keys with FIPS-197 / known expected
// round keys; strobes are checked by a scoreboard monitor, timing and read
// port by the stimulus process.
module tb_aes_key_expander;

  logic         Clock;
  logic         ResetN;
  logic [127:0] CipherKey;
  logic         KeyValid;
  logic         KeyReady;
  logic [3:0]   RoundIdx;
  logic [127:0] RoundKey;
  logic         KeyStrobe;
  logic [3:0]   KeyStrobeIdx;
  logic [127:0] KeyStrobeData;
  logic         KeysValid;

  aes_key_expander dut (
    .Clock         (Clock),
    .ResetN        (ResetN),
    .CipherKey     (CipherKey),
    .KeyValid      (KeyValid),
    .KeyReady      (KeyReady),
    .RoundIdx      (RoundIdx),
    .RoundKey      (RoundKey),
    .KeyStrobe     (KeyStrobe),
    .KeyStrobeIdx  (KeyStrobeIdx),
    .KeyStrobeData (KeyStrobeData),
    .KeysValid     (KeysValid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         chk;
  } exp_t;

  exp_t         sb_q [$];
  logic [127:0] fips_rk [11];
  logic [127:0] zero_rk [11];
  logic         zero_chk [11];
  int           n_cmp = 0;
  int           n_bad = 0;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] JunkKey = 128'h0123456789abcdeffedcba9876543210;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_set(input int set_id);
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.idx  = 4'(i);
      e.data = (set_id == 0) ? fips_rk[i] : zero_rk[i];
      e.chk  = (set_id == 0) ? 1'b1 : zero_chk[i];
      sb_q.push_back(e);
    end
  endtask

  // Monitor: every strobe must match the next expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (ResetN && KeyStrobe) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: idx %0d with empty scoreboard", KeyStrobeIdx);
        end else begin
          e = sb_q.pop_front();
          check("strobe_idx", 128'(KeyStrobeIdx), 128'(e.idx));
          if (e.chk) check($sformatf("strobe_data[%0d]", e.idx), KeyStrobeData, e.data);
        end
      end
    end
  end

  // Issues a key at posedge+1, then checks acceptance, latency and ready-low length.
  // Called at posedge+1; returns at posedge+1 of the first DONE cycle.
  task automatic run_key(input logic [127:0] key, input int set_id, input bit hold_junk);
    int waited;
    int edges;
    int ready_low;
    waited = 0;
    while (!KeyReady && waited < 30) begin
      @(posedge Clock); #1;
      waited++;
    end
    check("ready_before_handshake", 128'(KeyReady), 128'(1));
    push_set(set_id);
    CipherKey = key;
    KeyValid  = 1'b1;
    @(posedge Clock); #1;
    check("keys_valid_clear_after_hs", 128'(KeysValid), 128'(0));
    if (hold_junk) CipherKey = JunkKey;
    else           KeyValid  = 1'b0;
    edges     = 0;
    ready_low = 0;
    while (!KeysValid && edges < 20) begin
      if (!KeyReady) ready_low++;
      if (edges == 9) KeyValid = 1'b0;
      @(posedge Clock); #1;
      edges++;
    end
    KeyValid = 1'b0;
    check("keys_valid_latency", 128'(edges), 128'(10));
    check("ready_low_cycles", 128'(ready_low), 128'(10));
    check("ready_in_done", 128'(KeyReady), 128'(1));
  endtask

  task automatic read_check(input logic [3:0] idx, input logic [127:0] exp);
    RoundIdx = idx;
    #1;
    check($sformatf("round_key[%0d]", idx), RoundKey, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    fips_rk[0]  = FipsKey;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) begin
      zero_rk[i]  = '0;
      zero_chk[i] = (i == 0 || i == 1 || i == 10);
    end
    zero_rk[1]  = 128'h62636363626363636263636362636363;
    zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    ResetN    = 1'b0;
    KeyValid  = 1'b0;
    CipherKey = '0;
    RoundIdx  = 4'd0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_ready", 128'(KeyReady), 128'(1));
    check("reset_keys_valid", 128'(KeysValid), 128'(0));
    check("reset_strobe", 128'(KeyStrobe), 128'(0));
    check("reset_strobe_idx", 128'(KeyStrobeIdx), 128'(0));
    check("reset_strobe_data", KeyStrobeData, 128'(0));
    check("reset_round_key0", RoundKey, 128'(0));
    ResetN = 1'b1;
    @(posedge Clock); #1;

    // FIPS-197 key
    run_key(FipsKey, 0, 1'b0);
    read_check(4'd0, fips_rk[0]);
    read_check(4'd1, fips_rk[1]);
    read_check(4'd10, fips_rk[10]);
    for (int i = 11; i < 16; i++) read_check(4'(i), 128'(0));

    // All-zero key with a junk key held on KeyValid throughout EXPAND
    run_key(128'(0), 1, 1'b1);
    read_check(4'd0, zero_rk[0]);
    read_check(4'd1, zero_rk[1]);
    read_check(4'd10, zero_rk[10]);

    // Back-to-back: next key in the first DONE cycle
    run_key(FipsKey, 0, 1'b0);
    for (int i = 0; i < 11; i++) read_check(4'(i), fips_rk[i]);

    // Reset in the middle of an expansion (cnt = 5)
    push_set(0);
    RoundIdx  = 4'd0;
    CipherKey = FipsKey;
    KeyValid  = 1'b1;
    @(posedge Clock); #1;
    KeyValid = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    ResetN = 1'b0;
    #1;
    sb_q.delete();
    check("midreset_ready", 128'(KeyReady), 128'(1));
    check("midreset_keys_valid", 128'(KeysValid), 128'(0));
    check("midreset_strobe", 128'(KeyStrobe), 128'(0));
    check("midreset_strobe_idx", 128'(KeyStrobeIdx), 128'(0));
    check("midreset_strobe_data", KeyStrobeData, 128'(0));
    check("midreset_round_key0", RoundKey, 128'(0));
    @(posedge Clock); #1;
    ResetN = 1'b1;
    @(posedge Clock); #1;

    run_key(128'(0), 1, 1'b0);
    read_check(4'd1, zero_rk[1]);
    read_check(4'd10, zero_rk[10]);
    read_check(4'd15, 128'(0));

    repeat (3) @(posedge Clock);
    #1;
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
